// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and data ports of the core.
// Two-state request/ack FSM with round-robin tie breaking and a sticky wait-timeout flag.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_err
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t      state_q, state_d;
  owner_t      grant_q, grant_d;
  owner_t      last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic        mem_err_q, mem_err_d;

  logic        i_elig, d_elig;
  logic        pick_d;

  // A requester in its consume (valid) cycle must not be granted again.
  assign i_elig = if_req & ~if_valid_q;
  assign d_elig = d_req & ~d_valid_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;
    mem_err_d   = mem_err_q;
    pick_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_elig & d_elig) begin
          pick_d = (last_q == OWN_I);
          last_d = pick_d ? OWN_D : OWN_I;
        end else begin
          pick_d = d_elig;
        end
        if (i_elig | d_elig) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          cnt_d     = 8'd0;
          if (pick_d) begin
            grant_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            grant_d     = OWN_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 32'd0;
            mem_be_d    = 4'b1111;
          end
        end
      end

      BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (grant_q == OWN_I) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // The access keeps waiting; the flag only reports the overrun.
          if (cnt_d >= TO) mem_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= OWN_I;
      last_q      <= OWN_I;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'b0000;
      if_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_valid_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign mem_err   = mem_err_q;
  assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule
